// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants and types for the registered ALU control block.
// Optional mult/div sequencing is enabled by defining ALU_CTRL_MULDIV_EN.
package alu_ctrl_pkg;

    // ALUOp encodings produced by the main control unit
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // R-type funct field values
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // I-type opcode values
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    // Native operation codes; wider OP_W builds zero-extend these
    localparam int OP_CODE_W = 4;
    localparam logic [OP_CODE_W-1:0] OP_AND  = 4'b0000;
    localparam logic [OP_CODE_W-1:0] OP_OR   = 4'b0001;
    localparam logic [OP_CODE_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [OP_CODE_W-1:0] OP_XOR  = 4'b0011;
    localparam logic [OP_CODE_W-1:0] OP_SLL  = 4'b0100;
    localparam logic [OP_CODE_W-1:0] OP_SRL  = 4'b0101;
    localparam logic [OP_CODE_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [OP_CODE_W-1:0] OP_SLT  = 4'b0111;
    localparam logic [OP_CODE_W-1:0] OP_SRA  = 4'b1000;
    localparam logic [OP_CODE_W-1:0] OP_SLTU = 4'b1001;
    localparam logic [OP_CODE_W-1:0] OP_LUI  = 4'b1010;
    localparam logic [OP_CODE_W-1:0] OP_NOR  = 4'b1100;
    localparam logic [OP_CODE_W-1:0] OP_MULT = 4'b1101;
    localparam logic [OP_CODE_W-1:0] OP_DIV  = 4'b1110;

    // Mult/div sequencer state
    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// alu_ctrl_pipe_if: decode-side input, EX-side output and status of the ALU control register.
// Status signals busy/md_done are only active when ALU_CTRL_MULDIV_EN is defined.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high.
// valid must not depend on ready; once raised, valid and its payload stay stable until the
// transfer. ready may be raised or dropped freely. flush overrides any transfer into the block.
interface alu_ctrl_pipe_if #(
    parameter int OP_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [5:0]      funct;
    logic [5:0]      opcode;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] operation;
    logic            illegal;
    logic            busy;
    logic            md_done;

    // Upstream decode plus EX stage view (drives requests, consumes results)
    modport master (
        output in_valid, alu_op, funct, opcode, flush, out_ready,
        input  in_ready, out_valid, operation, illegal, busy, md_done
    );

    // ALU control block view
    modport slave (
        input  in_valid, alu_op, funct, opcode, flush, out_ready,
        output in_ready, out_valid, operation, illegal, busy, md_done
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: purely combinational ALUOp/funct/opcode to operation decode.
// mult/div recognition (is_mult/is_div ports) exists only when ALU_CTRL_MULDIV_EN is defined;
// otherwise those funct codes fall through to illegal.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [1:0]      alu_op,
    input  logic [5:0]      funct,
    input  logic [5:0]      opcode,
    output logic [OP_W-1:0] operation,
    output logic            illegal
`ifdef ALU_CTRL_MULDIV_EN
    ,
    output logic            is_mult,
    output logic            is_div
`endif
);

    logic [OP_CODE_W-1:0] code;

    // Map the instruction fields to an operation; unknown codes give AND with illegal set
    always_comb begin
        code    = OP_AND;
        illegal = 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
        is_mult = 1'b0;
        is_div  = 1'b0;
`endif
        case (alu_op)
            ALUOP_MEM: code = OP_ADD;
            ALUOP_BEQ: code = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: code = OP_ADD;
                    FN_SUB, FN_SUBU: code = OP_SUB;
                    FN_AND:          code = OP_AND;
                    FN_OR:           code = OP_OR;
                    FN_XOR:          code = OP_XOR;
                    FN_NOR:          code = OP_NOR;
                    FN_SLT:          code = OP_SLT;
                    FN_SLTU:         code = OP_SLTU;
                    FN_SLL:          code = OP_SLL;
                    FN_SRL:          code = OP_SRL;
                    FN_SRA:          code = OP_SRA;
`ifdef ALU_CTRL_MULDIV_EN
                    FN_MULT: begin
                        code    = OP_MULT;
                        is_mult = 1'b1;
                    end
                    FN_DIV: begin
                        code   = OP_DIV;
                        is_div = 1'b1;
                    end
`endif
                    default:         illegal = 1'b1;
                endcase
            end
            ALUOP_ITYPE: begin
                case (opcode)
                    OPC_ADDI:  code = OP_ADD;
                    OPC_ANDI:  code = OP_AND;
                    OPC_ORI:   code = OP_OR;
                    OPC_XORI:  code = OP_XOR;
                    OPC_SLTI:  code = OP_SLT;
                    OPC_SLTIU: code = OP_SLTU;
                    OPC_LUI:   code = OP_LUI;
                    default:   illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign operation = OP_W'(code);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered ALU control at the ID/EX boundary. One-entry valid/ready output
// register with flush; when ALU_CTRL_MULDIV_EN is defined, an accepted mult/div holds off new
// input for MULT_LAT/DIV_LAT cycles while busy is high, pulsing md_done on the last one.
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 16,
    parameter int CNT_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_ctrl_pipe_if.slave       bus,
    output md_state_t            dbg_state
);

    localparam int MD_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;

    // Reject configurations the counter or the opcode field cannot represent
    if (OP_W < OP_CODE_W || MULT_LAT < 1 || DIV_LAT < 1 || (1 << CNT_W) <= MD_MAX_LAT) begin : g_bad_cfg
        $error("alu_ctrl_pipe: invalid OP_W/MULT_LAT/DIV_LAT/CNT_W combination");
    end

    logic [OP_W-1:0] dec_operation;
    logic            dec_illegal;
    logic            accept;

    logic            out_valid_q;
    logic [OP_W-1:0] operation_q;
    logic            illegal_q;

`ifdef ALU_CTRL_MULDIV_EN
    logic            dec_is_mult;
    logic            dec_is_div;
    md_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic            busy_q;
    logic            md_done_q;
`endif

    alu_ctrl_decode #(
        .OP_W(OP_W)
    ) u_decode (
        .alu_op    (bus.alu_op),
        .funct     (bus.funct),
        .opcode    (bus.opcode),
        .operation (dec_operation),
        .illegal   (dec_illegal)
`ifdef ALU_CTRL_MULDIV_EN
        ,
        .is_mult   (dec_is_mult),
        .is_div    (dec_is_div)
`endif
    );

`ifdef ALU_CTRL_MULDIV_EN
    assign bus.in_ready = (state == IDLE) && (!out_valid_q || bus.out_ready);
`else
    assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

    assign accept = bus.in_valid && bus.in_ready;

    // Output register: flush squashes, accept loads, consumption without refill empties, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            operation_q <= '0;
            illegal_q   <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            operation_q <= dec_operation;
            illegal_q   <= dec_illegal;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef ALU_CTRL_MULDIV_EN
    // Mult/div sequencer: busy/md_done are registered so busy covers exactly LAT cycles
    // starting after the accept, and md_done marks the cycle where the counter reads 1
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state     <= IDLE;
            cnt       <= '0;
            busy_q    <= 1'b0;
            md_done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (dec_is_mult || dec_is_div)) begin
                        state     <= MD_BUSY;
                        busy_q    <= 1'b1;
                        cnt       <= dec_is_mult ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                        md_done_q <= dec_is_mult ? (MULT_LAT == 1) : (DIV_LAT == 1);
                    end
                end
                MD_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        busy_q    <= 1'b0;
                        md_done_q <= 1'b0;
                    end else begin
                        cnt       <= cnt - CNT_W'(1);
                        md_done_q <= (cnt == CNT_W'(2));
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    busy_q    <= 1'b0;
                    md_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.md_done = md_done_q;
    assign dbg_state   = state;
`else
    assign bus.busy    = 1'b0;
    assign bus.md_done = 1'b0;
    assign dbg_state   = IDLE;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.operation = operation_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb_alu_ctrl_pipe: directed bench for alu_ctrl_pipe with a queue scoreboard.
// Covers both builds; mult/div sequencing checks apply when ALU_CTRL_MULDIV_EN is defined.
module tb_alu_ctrl_pipe;
    import alu_ctrl_pkg::*;

    localparam int OP_W     = 4;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 16;
    localparam int CNT_W    = 5;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic            ill;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst;
    md_state_t dbg_state;

    alu_ctrl_pipe_if #(.OP_W(OP_W)) bus ();

    alu_ctrl_pipe #(
        .OP_W     (OP_W),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    exp_t exp_q[$];
    exp_t cur_exp;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic busy_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Driver tasks: inputs change #1 after posedge; everything is observed at negedge
    task automatic drive(input logic v, input logic [1:0] aop, input logic [5:0] fn,
                         input logic [5:0] opc, input logic [3:0] eop, input logic eill);
        bus.in_valid = v;
        bus.alu_op   = aop;
        bus.funct    = fn;
        bus.opcode   = opc;
        cur_exp      = '{op: OP_W'(eop), ill: eill};
    endtask

    task automatic sample();
        @(negedge clk);
        if (bus.in_valid && bus.in_ready && !bus.flush && !rst) exp_q.push_back(cur_exp);
        if (bus.busy) busy_seen = 1'b1;
    endtask

    task automatic advance();
        logic fl;
        fl = bus.flush;
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
    endtask

    task automatic issue(input logic [1:0] aop, input logic [5:0] fn, input logic [5:0] opc,
                         input logic [3:0] eop, input logic eill);
        bus.out_ready = 1'b1;
        drive(1'b1, aop, fn, opc, eop, eill);
        sample();
        check("issue_in_ready", 32'(bus.in_ready), 1);
        advance();
    endtask

    // Scoreboard monitor: every output handshake must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty: got op 0x%0h ill %0b, expected no output", bus.operation, bus.illegal);
            end else begin
                e = exp_q.pop_front();
                check("sb_op", 32'(bus.operation), 32'(e.op));
                check("sb_illegal", 32'(bus.illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_op    = 2'b00;
        bus.funct     = 6'b0;
        bus.opcode    = 6'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        cur_exp       = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_operation", 32'(bus.operation), 0);
        check("rst_illegal", 32'(bus.illegal), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_md_done", 32'(bus.md_done), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First transaction: sub, latency one cycle
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b10, 6'b100010, 6'b0, 4'b0110, 1'b0);
        sample();
        check("t1_in_ready", 32'(bus.in_ready), 1);
        advance();
        drive(1'b0, 2'b00, 6'b0, 6'b0, 4'b0000, 1'b0);
        sample();
        check("t1_out_valid", 32'(bus.out_valid), 1);
        check("t1_op", 32'(bus.operation), 6);
        check("t1_in_ready", 32'(bus.in_ready), 1);
        advance();

        // Back-to-back decode vectors
        issue(2'b11, 6'b0, 6'b001101, 4'b0001, 1'b0);
        issue(2'b11, 6'b0, 6'b001111, 4'b1010, 1'b0);
        issue(2'b11, 6'b0, 6'b000100, 4'b0000, 1'b1);
        issue(2'b00, 6'b100010, 6'b0, 4'b0010, 1'b0);
        issue(2'b01, 6'b100000, 6'b0, 4'b0110, 1'b0);
        issue(2'b10, 6'b100000, 6'b0, 4'b0010, 1'b0);
        issue(2'b10, 6'b100001, 6'b0, 4'b0010, 1'b0);
        issue(2'b10, 6'b100011, 6'b0, 4'b0110, 1'b0);
        issue(2'b10, 6'b100100, 6'b0, 4'b0000, 1'b0);
        issue(2'b10, 6'b100101, 6'b0, 4'b0001, 1'b0);
        issue(2'b10, 6'b100110, 6'b0, 4'b0011, 1'b0);
        issue(2'b10, 6'b100111, 6'b0, 4'b1100, 1'b0);
        issue(2'b10, 6'b101010, 6'b0, 4'b0111, 1'b0);
        issue(2'b10, 6'b101011, 6'b0, 4'b1001, 1'b0);
        issue(2'b10, 6'b000000, 6'b0, 4'b0100, 1'b0);
        issue(2'b10, 6'b000010, 6'b0, 4'b0101, 1'b0);
        issue(2'b10, 6'b000011, 6'b0, 4'b1000, 1'b0);
        issue(2'b10, 6'b000001, 6'b0, 4'b0000, 1'b1);
        issue(2'b11, 6'b0, 6'b001000, 4'b0010, 1'b0);
        issue(2'b11, 6'b0, 6'b001100, 4'b0000, 1'b0);
        issue(2'b11, 6'b0, 6'b001110, 4'b0011, 1'b0);
        issue(2'b11, 6'b0, 6'b001010, 4'b0111, 1'b0);
        issue(2'b11, 6'b0, 6'b001011, 4'b1001, 1'b0);
        issue(2'b11, 6'b100101, 6'b100011, 4'b0000, 1'b1);

        // Backpressure: nor held for 3 cycles while an and waits upstream
        issue(2'b10, 6'b100111, 6'b0, 4'b1100, 1'b0);
        drive(1'b1, 2'b10, 6'b100100, 6'b0, 4'b0000, 1'b0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("bp_in_ready", 32'(bus.in_ready), 0);
            check("bp_out_valid", 32'(bus.out_valid), 1);
            check("bp_op", 32'(bus.operation), 12);
            advance();
        end
        bus.out_ready = 1'b1;
        sample();
        check("bp_release_in_ready", 32'(bus.in_ready), 1);
        advance();
        drive(1'b0, 2'b00, 6'b0, 6'b0, 4'b0000, 1'b0);
        sample();
        check("bp_next_valid", 32'(bus.out_valid), 1);
        check("bp_next_op", 32'(bus.operation), 0);
        advance();

        // Flush a held illegal entry, then flush a same-cycle accept
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b11, 6'b0, 6'b000100, 4'b0000, 1'b1);
        sample();
        check("fl_in_ready", 32'(bus.in_ready), 1);
        advance();
        drive(1'b1, 2'b00, 6'b0, 6'b0, 4'b0010, 1'b0);
        bus.flush = 1'b1;
        sample();
        check("fl_held_valid", 32'(bus.out_valid), 1);
        check("fl_held_illegal", 32'(bus.illegal), 1);
        advance();
        sample();
        check("fl_out_valid", 32'(bus.out_valid), 0);
        check("fl_illegal", 32'(bus.illegal), 0);
        check("fl_in_ready", 32'(bus.in_ready), 1);
        advance();
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 2'b00, 6'b0, 6'b0, 4'b0000, 1'b0);
        sample();
        check("fl_discard_valid", 32'(bus.out_valid), 0);
        advance();
        issue(2'b00, 6'b0, 6'b0, 4'b0010, 1'b0);

`ifdef ALU_CTRL_MULDIV_EN
        // mult: busy for MULT_LAT cycles, md_done on the last; an add waits upstream
        issue(2'b10, 6'b011000, 6'b0, 4'b1101, 1'b0);
        drive(1'b1, 2'b00, 6'b0, 6'b0, 4'b0010, 1'b0);
        for (int k = 1; k <= MULT_LAT; k++) begin
            sample();
            check("mult_busy", 32'(bus.busy), 1);
            check("mult_md_done", 32'(bus.md_done), (k == MULT_LAT) ? 1 : 0);
            check("mult_in_ready", 32'(bus.in_ready), 0);
            check("mult_state", 32'(dbg_state), 32'(MD_BUSY));
            advance();
        end
        sample();
        check("mult_end_busy", 32'(bus.busy), 0);
        check("mult_end_md_done", 32'(bus.md_done), 0);
        check("mult_end_in_ready", 32'(bus.in_ready), 1);
        advance();

        // div: DIV_LAT busy cycles
        issue(2'b10, 6'b011010, 6'b0, 4'b1110, 1'b0);
        drive(1'b1, 2'b00, 6'b0, 6'b0, 4'b0010, 1'b0);
        for (int k = 1; k <= DIV_LAT; k++) begin
            sample();
            check("div_busy", 32'(bus.busy), 1);
            check("div_md_done", 32'(bus.md_done), (k == DIV_LAT) ? 1 : 0);
            check("div_in_ready", 32'(bus.in_ready), 0);
            advance();
        end
        sample();
        check("div_end_busy", 32'(bus.busy), 0);
        check("div_end_in_ready", 32'(bus.in_ready), 1);
        advance();

        // Flush on the 2nd busy cycle of a div
        issue(2'b10, 6'b011010, 6'b0, 4'b1110, 1'b0);
        drive(1'b0, 2'b00, 6'b0, 6'b0, 4'b0000, 1'b0);
        sample();
        check("dflush_busy1", 32'(bus.busy), 1);
        advance();
        bus.flush = 1'b1;
        sample();
        check("dflush_busy2", 32'(bus.busy), 1);
        advance();
        bus.flush = 1'b0;
        drive(1'b1, 2'b00, 6'b0, 6'b0, 4'b0010, 1'b0);
        sample();
        check("dflush_busy", 32'(bus.busy), 0);
        check("dflush_md_done", 32'(bus.md_done), 0);
        check("dflush_out_valid", 32'(bus.out_valid), 0);
        check("dflush_in_ready", 32'(bus.in_ready), 1);
        advance();
        drive(1'b0, 2'b00, 6'b0, 6'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            sample();
            check("dflush_no_md_done", 32'(bus.md_done), 0);
            advance();
        end
`else
        // Without mult/div support both funct codes are illegal and never stall
        issue(2'b10, 6'b011000, 6'b0, 4'b0000, 1'b1);
        issue(2'b10, 6'b011010, 6'b0, 4'b0000, 1'b1);
        drive(1'b0, 2'b00, 6'b0, 6'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            sample();
            check("nomd_busy", 32'(bus.busy), 0);
            check("nomd_md_done", 32'(bus.md_done), 0);
            advance();
        end
        check("nomd_busy_seen", 32'(busy_seen), 0);
`endif

        // Drain and report
        drive(1'b0, 2'b00, 6'b0, 6'b0, 4'b0000, 1'b0);
        bus.out_ready = 1'b1;
        repeat (3) begin
            sample();
            advance();
        end
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
